// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants for the 16-bit MIPS core pipeline.
//   DATA_W, REG_ADDR_W : datapath and register-index widths
//   PIPE_W             : width of the MEM/WB pipeline register
//   WB_*               : bit positions of the MEM/WB register fields
//   MEM_IDLE/MEM_BUSY  : MEM-stage cache handshake FSM encoding
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int PIPE_W     = 2 * DATA_W + REG_ADDR_W + 2;

  // MEM/WB register layout: {load data, alu result, reg_write_en, dest, wb_sel}
  localparam int WB_MEMDATA_HI = 36;
  localparam int WB_MEMDATA_LO = 21;
  localparam int WB_ALU_HI     = 20;
  localparam int WB_ALU_LO     = 5;
  localparam int WB_WEN        = 4;
  localparam int WB_DEST_HI    = 3;
  localparam int WB_DEST_LO    = 1;
  localparam int WB_SEL        = 0;

  localparam logic [0:0] MEM_IDLE = 1'b0;
  localparam logic [0:0] MEM_BUSY = 1'b1;

endpackage

// File: rtl/mem_wb_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_reg
// MEM/WB pipeline register with bubble insertion.
//   clk    : pipeline clock
//   rst_n  : asynchronous active-low clear
//   bubble : load all-zero (no-op) instead of d on this edge
//   d      : next pipeline word
//   q      : registered pipeline word
// ---------------------------------------------------------------------------
module mem_wb_reg #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Pipeline register: a bubble is an all-zero word, i.e. no register write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= {W{1'b0}};
    end else if (bubble) begin
      q <= {W{1'b0}};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// MEM stage of the 16-bit MIPS core: issues loads/stores to the data cache,
// stalls the pipe while a cache miss is serviced, and owns the MEM/WB register.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   ex_*                 : EX/MEM pipeline inputs (held stable while stalled)
//   cache_req/we/addr/wdata, cache_rdata/ready : cache req/ready handshake
//   mem_stall            : freeze PC, IF/ID, ID/EX, EX/MEM
//   mem_op_dest          : MEM-stage destination for hazard detection (0 = none)
//   wb_pipe_reg          : MEM/WB register {memdata, alu, wen, dest, wb_sel}
//   stall_cycles         : saturating stall counter (MEM_STALL_CNT_EN only)
// Configuration macro: MEM_STALL_CNT_EN enables the stall counter and port.
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int DATA_W      = mips_pkg::DATA_W,
  parameter int REG_ADDR_W  = mips_pkg::REG_ADDR_W,
`ifdef MEM_STALL_CNT_EN
  parameter int STALL_CNT_W = 16,
`endif
  localparam int PIPE_W     = 2 * DATA_W + REG_ADDR_W + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_reg_write_en,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_wb_sel,
  output logic                  cache_req,
  output logic                  cache_we,
  output logic [DATA_W-1:0]     cache_addr,
  output logic [DATA_W-1:0]     cache_wdata,
  input  logic [DATA_W-1:0]     cache_rdata,
  input  logic                  cache_ready,
  output logic                  mem_stall,
  output logic [REG_ADDR_W-1:0] mem_op_dest,
  output logic [PIPE_W-1:0]     wb_pipe_reg
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  import mips_pkg::*;

  logic                mem_op_s;
  logic                is_load_s;
  logic                req_s;
  logic [0:0]          state_r;
  logic [0:0]          state_nxt_s;
  logic                bubble_s;
  logic [DATA_W-1:0]   load_data_s;
  logic [PIPE_W-1:0]   wb_next_s;

  // Read+write together is treated as a write, so it is never a load.
  assign mem_op_s  = ex_valid & (ex_mem_read | ex_mem_write);
  assign is_load_s = ex_mem_read & ~ex_mem_write;

  // Address/data come straight from EX/MEM; they hold still during a stall.
  assign cache_addr  = ex_alu_result;
  assign cache_wdata = ex_store_data;

  // rst_n gating makes a mid-access reset drop the request immediately,
  // even though the EX/MEM inputs may still describe a memory op.
  assign cache_we  = rst_n & ex_valid & ex_mem_write;
  assign cache_req = rst_n & req_s;
  assign mem_stall = rst_n & mem_op_s & ~cache_ready;

  // Request source: new op in IDLE, held high while waiting in BUSY.
  always_comb begin
    req_s = 1'b0;
    case (state_r)
      MEM_IDLE: req_s = mem_op_s;
      MEM_BUSY: req_s = 1'b1;
      default:  req_s = 1'b0;
    endcase
  end

  // Handshake FSM next state: enter BUSY on a miss, leave when ready.
  always_comb begin
    state_nxt_s = MEM_IDLE;
    case (state_r)
      MEM_IDLE: begin
        if (mem_op_s && !cache_ready) begin
          state_nxt_s = MEM_BUSY;
        end else begin
          state_nxt_s = MEM_IDLE;
        end
      end
      MEM_BUSY: begin
        if (cache_ready) begin
          state_nxt_s = MEM_IDLE;
        end else begin
          state_nxt_s = MEM_BUSY;
        end
      end
      default: state_nxt_s = MEM_IDLE;
    endcase
  end

  // Handshake FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= MEM_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Only loads carry cache data into write-back; stores and ALU ops carry 0.
  assign load_data_s = is_load_s ? cache_rdata : {DATA_W{1'b0}};
  assign wb_next_s   = {load_data_s, ex_alu_result, ex_reg_write_en, ex_dest, ex_wb_sel};
  assign bubble_s    = mem_stall | ~ex_valid;

  assign mem_op_dest = (ex_valid & ex_reg_write_en) ? ex_dest : {REG_ADDR_W{1'b0}};

  mem_wb_reg #(
    .W (PIPE_W)
  ) u_mem_wb_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (bubble_s),
    .d      (wb_next_s),
    .q      (wb_pipe_reg)
  );

`ifdef MEM_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  // Saturating count of stalled cycles; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (mem_stall && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;
`else
  // No stall counter in this build.
`endif

endmodule
